// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the write-back stage: exception codes, register
// addresses, Status/Cause bit positions, MTC0 write masks and the MEM->WB bus layout.
package cp0_pkg;

    localparam logic [31:0] EXC_ENTRY  = 32'hBFC00380;
    localparam logic [31:0] STATUS_RST = 32'h00400000;

    typedef enum logic [4:0] {
        EXC_INT  = 5'h00,
        EXC_ADEL = 5'h04,
        EXC_ADES = 5'h05,
        EXC_SYS  = 5'h08,
        EXC_BP   = 5'h09,
        EXC_RI   = 5'h0A,
        EXC_OV   = 5'h0C
    } exc_code_e;

    // CP0 addresses are {reg[4:0], sel[2:0]}
    localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
    localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
    localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
    localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
    localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
    localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_IM_HI = 15;

    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_IP_LO   = 8;
    localparam int CAUSE_IP_HI   = 15;
    localparam int CAUSE_HWIP_LO = 10;
    localparam int CAUSE_CODE_LO = 2;
    localparam int CAUSE_CODE_HI = 6;

    localparam logic [31:0] STATUS_WMASK = 32'h0000FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;

    typedef struct packed {
        logic        rsvd;
        logic        inst_jbr;
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0_addr;
        logic        syscall;
        logic        brk;
        logic        ov;
        logic        adel;
        logic        ades;
        logic        ri;
        logic        eret;
        logic [31:0] exe_result;
        logic [31:0] pc;
        logic [3:0]  wbytes;
    } mem_wb_bus_t;

    // Highest-priority source wins; order is INT, RI, Ov, Sys, Bp, AdEL, AdES.
    function automatic exc_code_e exc_select(input logic intr, input logic ri, input logic ov,
                                             input logic sys, input logic bp, input logic adel,
                                             input logic ades);
        exc_code_e code;
        code = EXC_ADES;
        if (intr)      code = EXC_INT;
        else if (ri)   code = EXC_RI;
        else if (ov)   code = EXC_OV;
        else if (sys)  code = EXC_SYS;
        else if (bp)   code = EXC_BP;
        else if (adel) code = EXC_ADEL;
        else if (ades) code = EXC_ADES;
        return code;
    endfunction

endpackage

// File: rtl/wb_cp0.sv
// CP0 Status/Cause/EPC/BadVAddr register set, updated by exception/ERET/MTC0 strobes.
// Define WB_CP0_TIMER_EN to add the Count/Compare timer driving Cause.TI and IP[7].
module wb_cp0
    import cp0_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  hw_int_i,
    input  logic        exc_i,
    input  logic [4:0]  exc_code_i,
    input  logic        exc_bd_i,
    input  logic [31:0] exc_pc_i,
    input  logic        badv_we_i,
    input  logic [31:0] badv_i,
    input  logic        eret_i,
    input  logic        mtc0_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] rdata_o,
    output logic        int_pending_o
);

    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] count_rd, compare_rd;
    logic        timer_hit;

`ifdef WB_CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        tick_q, tick_d;

    always_comb begin
        tick_d    = ~tick_q;
        count_d   = tick_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        if (mtc0_i && addr_i == CP0_COUNT)   count_d   = wdata_i;
        if (mtc0_i && addr_i == CP0_COMPARE) compare_d = wdata_i;
    end

    // Match is flagged on the cycle Count steps onto Compare, not while idle at reset.
    assign timer_hit  = tick_q && (count_q + 32'd1 == compare_q);
    assign count_rd   = count_q;
    assign compare_rd = compare_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            tick_q    <= tick_d;
        end
    end
`else
    assign timer_hit  = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

    always_comb begin
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        badv_d   = badv_q;
        if (timer_hit) cause_d[CAUSE_TI] = 1'b1;
        if (exc_i) begin
            cause_d[CAUSE_BD]                    = exc_bd_i;
            cause_d[CAUSE_CODE_HI:CAUSE_CODE_LO] = exc_code_i;
            epc_d                                = exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
            status_d[STATUS_EXL]                 = 1'b1;
            if (badv_we_i) badv_d = badv_i;
        end else if (eret_i) begin
            status_d[STATUS_EXL] = 1'b0;
        end else if (mtc0_i) begin
            case (addr_i)
                CP0_STATUS:  status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                CP0_CAUSE:   cause_d  = (cause_d & ~CAUSE_WMASK) | (wdata_i & CAUSE_WMASK);
                CP0_EPC:     epc_d    = wdata_i;
                CP0_COMPARE: cause_d[CAUSE_TI] = 1'b0;
                default:     ;
            endcase
        end
        // Hardware pending bits track the pins every cycle; TI stays 0 without the timer.
        cause_d[CAUSE_IP_HI:CAUSE_HWIP_LO] = hw_int_i;
        cause_d[CAUSE_IP_HI]               = hw_int_i[5] | cause_d[CAUSE_TI];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= STATUS_RST;
            cause_q  <= 32'd0;
            epc_q    <= 32'd0;
            badv_q   <= 32'd0;
        end else begin
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            badv_q   <= badv_d;
        end
    end

    always_comb begin
        case (addr_i)
            CP0_STATUS:   rdata_o = status_q;
            CP0_CAUSE:    rdata_o = cause_q;
            CP0_EPC:      rdata_o = epc_q;
            CP0_BADVADDR: rdata_o = badv_q;
            CP0_COUNT:    rdata_o = count_rd;
            CP0_COMPARE:  rdata_o = compare_rd;
            default:      rdata_o = 32'd0;
        endcase
    end

    assign int_pending_o = status_q[STATUS_IE] & ~status_q[STATUS_EXL] &
                           (|(cause_q[CAUSE_IP_HI:CAUSE_IP_LO] & status_q[STATUS_IM_HI:STATUS_IM_LO]));
    assign status_o      = status_q;
    assign cause_o       = cause_q;
    assign epc_o         = epc_q;
    assign badvaddr_o    = badv_q;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires register-file, HI/LO and CP0 effects, commits precise
// exceptions/ERET and flushes upstream via cancel. Optional timer: WB_CP0_TIMER_EN.
module wb_stage
    import cp0_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         MEM_over,
    input  logic [160:0] MEM_WB_bus,
    output logic         WB_allow_in,
    output logic         WB_valid,
    output logic         WB_over,
    output logic [3:0]   rf_wen,
    output logic [4:0]   rf_wdest,
    output logic [31:0]  rf_wdata,
    output logic [4:0]   WB_wdest,
    output logic         WB_hi_write,
    output logic         WB_lo_write,
    output logic [31:0]  WB_hi_data,
    output logic [31:0]  WB_lo_data,
    output logic [31:0]  HI_data,
    output logic [31:0]  LO_data,
    output logic [31:0]  cp0r_status,
    output logic [31:0]  cp0r_cause,
    output logic [31:0]  cp0r_epc,
    output logic [31:0]  cp0r_badvaddr,
    output logic         cancel,
    output logic         exc_valid,
    output logic [31:0]  exc_pc,
    input  logic [5:0]   hw_int,
    output logic [31:0]  debug_wb_pc
);

    mem_wb_bus_t bus_q, bus_d;
    logic        valid_q, valid_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        last_jbr_q, last_jbr_d;
    logic        int_pending, exc_src, exc_taken, eret_taken, mtc0_we, badv_we;
    exc_code_e   exc_code;
    logic [31:0] cp0_rdata;
    logic        unused_rsvd;

    // Handshake: WB always accepts (WB_allow_in=1); an instruction moves in on an edge
    // where MEM_over=1 and cancel=0, otherwise the stage goes empty for one cycle.
    always_comb begin
        valid_d = 1'b0;
        bus_d   = bus_q;
        if (MEM_over && !cancel) begin
            valid_d = 1'b1;
            bus_d   = mem_wb_bus_t'(MEM_WB_bus);
        end
        last_jbr_d = valid_q ? bus_q.inst_jbr : last_jbr_q;
        hi_d       = WB_hi_write ? bus_q.mem_result : hi_q;
        lo_d       = WB_lo_write ? bus_q.lo_result : lo_q;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            valid_q    <= 1'b0;
            bus_q      <= '0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            last_jbr_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            bus_q      <= bus_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            last_jbr_q <= last_jbr_d;
        end
    end

    assign exc_src    = int_pending | bus_q.ri | bus_q.ov | bus_q.syscall | bus_q.brk |
                        bus_q.adel | bus_q.ades;
    assign exc_taken  = valid_q & ~cp0r_status[STATUS_EXL] & exc_src;
    assign eret_taken = valid_q & bus_q.eret & ~exc_taken;
    assign mtc0_we    = valid_q & bus_q.mtc0 & ~exc_taken;
    assign exc_code   = exc_select(int_pending, bus_q.ri, bus_q.ov, bus_q.syscall, bus_q.brk,
                                   bus_q.adel, bus_q.ades);
    assign badv_we    = (exc_code == EXC_ADEL) || (exc_code == EXC_ADES);

    // MTC0 data travels in the general result field.
    wb_cp0 u_cp0 (
        .clk_i         (clk),
        .rst_i         (resetn),
        .hw_int_i      (hw_int),
        .exc_i         (exc_taken),
        .exc_code_i    (exc_code),
        .exc_bd_i      (last_jbr_q),
        .exc_pc_i      (bus_q.pc),
        .badv_we_i     (badv_we),
        .badv_i        (bus_q.exe_result),
        .eret_i        (eret_taken),
        .mtc0_i        (mtc0_we),
        .addr_i        (bus_q.cp0_addr),
        .wdata_i       (bus_q.mem_result),
        .status_o      (cp0r_status),
        .cause_o       (cp0r_cause),
        .epc_o         (cp0r_epc),
        .badvaddr_o    (cp0r_badvaddr),
        .rdata_o       (cp0_rdata),
        .int_pending_o (int_pending)
    );

    always_comb begin
        if (bus_q.mfc0)      rf_wdata = cp0_rdata;
        else if (bus_q.mfhi) rf_wdata = hi_q;
        else if (bus_q.mflo) rf_wdata = lo_q;
        else                 rf_wdata = bus_q.mem_result;
    end

    assign cancel      = exc_taken | eret_taken;
    assign exc_valid   = cancel;
    assign exc_pc      = exc_taken ? EXC_ENTRY : cp0r_epc;
    assign rf_wen      = {4{valid_q & bus_q.wen & ~exc_taken}} & bus_q.wbytes;
    assign rf_wdest    = bus_q.wdest;
    assign WB_wdest    = bus_q.wdest & {5{valid_q}};
    assign WB_hi_write = valid_q & bus_q.hi_write & ~exc_taken;
    assign WB_lo_write = valid_q & bus_q.lo_write & ~exc_taken;
    assign WB_hi_data  = bus_q.mem_result;
    assign WB_lo_data  = bus_q.lo_result;
    assign HI_data     = hi_q;
    assign LO_data     = lo_q;
    assign WB_allow_in = 1'b1;
    assign WB_valid    = valid_q;
    assign WB_over     = valid_q;
    assign debug_wb_pc = bus_q.pc;
    assign unused_rsvd = bus_q.rsvd;

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: retire, exceptions, ERET, MTC0 masks,
// HI/LO forwarding, interrupts and reset during a flush.
module tb_wb_stage;

    typedef struct packed {
        logic        rsvd;
        logic        inst_jbr;
        logic        wen;
        logic [4:0]  wdest;
        logic [31:0] mem_result;
        logic [31:0] lo_result;
        logic        hi_write;
        logic        lo_write;
        logic        mfhi;
        logic        mflo;
        logic        mtc0;
        logic        mfc0;
        logic [7:0]  cp0_addr;
        logic        syscall;
        logic        brk;
        logic        ov;
        logic        adel;
        logic        ades;
        logic        ri;
        logic        eret;
        logic [31:0] exe_result;
        logic [31:0] pc;
        logic [3:0]  wbytes;
    } tb_bus_t;

    logic         clk = 1'b0;
    logic         resetn;
    logic         MEM_over;
    logic [160:0] MEM_WB_bus;
    logic [5:0]   hw_int;
    logic         WB_allow_in, WB_valid, WB_over;
    logic [3:0]   rf_wen;
    logic [4:0]   rf_wdest, WB_wdest;
    logic [31:0]  rf_wdata;
    logic         WB_hi_write, WB_lo_write;
    logic [31:0]  WB_hi_data, WB_lo_data, HI_data, LO_data;
    logic [31:0]  cp0r_status, cp0r_cause, cp0r_epc, cp0r_badvaddr;
    logic         cancel, exc_valid;
    logic [31:0]  exc_pc, debug_wb_pc;

    int      n_cmp = 0;
    int      n_mis = 0;
    tb_bus_t b;

    wb_stage dut (
        .clk(clk), .resetn(resetn), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
        .WB_allow_in(WB_allow_in), .WB_valid(WB_valid), .WB_over(WB_over),
        .rf_wen(rf_wen), .rf_wdest(rf_wdest), .rf_wdata(rf_wdata), .WB_wdest(WB_wdest),
        .WB_hi_write(WB_hi_write), .WB_lo_write(WB_lo_write),
        .WB_hi_data(WB_hi_data), .WB_lo_data(WB_lo_data),
        .HI_data(HI_data), .LO_data(LO_data),
        .cp0r_status(cp0r_status), .cp0r_cause(cp0r_cause), .cp0r_epc(cp0r_epc),
        .cp0r_badvaddr(cp0r_badvaddr), .cancel(cancel), .exc_valid(exc_valid),
        .exc_pc(exc_pc), .hw_int(hw_int), .debug_wb_pc(debug_wb_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Present one instruction from MEM; on return it sits in WB (1 ns after the edge).
    task automatic issue(input tb_bus_t bi);
        @(negedge clk);
        MEM_WB_bus = bi;
        MEM_over   = 1'b1;
        @(posedge clk);
        #1;
        MEM_over   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic eret_at(input logic [31:0] pc);
        b = '0; b.eret = 1'b1; b.pc = pc;
        issue(b);
    endtask

    task automatic test_reset();
        resetn = 1'b1; MEM_over = 1'b0; MEM_WB_bus = '0; hw_int = 6'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (WB_valid !== 1'b0) begin n_mis++; $display("FAIL rst_valid: got %h expected 0", WB_valid); end
        n_cmp++; if (cp0r_status !== 32'h00400000) begin n_mis++; $display("FAIL rst_status: got %h expected 00400000", cp0r_status); end
        n_cmp++; if (cp0r_cause !== 32'h0) begin n_mis++; $display("FAIL rst_cause: got %h expected 0", cp0r_cause); end
        n_cmp++; if (cp0r_epc !== 32'h0 || cp0r_badvaddr !== 32'h0) begin n_mis++; $display("FAIL rst_epc_badv: got %h/%h expected 0/0", cp0r_epc, cp0r_badvaddr); end
        n_cmp++; if (HI_data !== 32'h0 || LO_data !== 32'h0) begin n_mis++; $display("FAIL rst_hilo: got %h/%h expected 0/0", HI_data, LO_data); end
        n_cmp++; if (cancel !== 1'b0 || rf_wen !== 4'h0) begin n_mis++; $display("FAIL rst_cancel_wen: got %h/%h expected 0/0", cancel, rf_wen); end
        n_cmp++; if (WB_allow_in !== 1'b1) begin n_mis++; $display("FAIL rst_allow_in: got %h expected 1", WB_allow_in); end
        resetn = 1'b0;
    endtask

    task automatic test_alu_write();
        b = '0; b.rsvd = 1'b1; b.wen = 1'b1; b.wdest = 5'd5; b.wbytes = 4'b1111;
        b.mem_result = 32'h12345678; b.pc = 32'hBFC00000;
        issue(b);
        n_cmp++; if (rf_wen !== 4'hF) begin n_mis++; $display("FAIL alu_wen: got %h expected f", rf_wen); end
        n_cmp++; if (rf_wdest !== 5'd5 || WB_wdest !== 5'd5) begin n_mis++; $display("FAIL alu_wdest: got %h/%h expected 05/05", rf_wdest, WB_wdest); end
        n_cmp++; if (rf_wdata !== 32'h12345678) begin n_mis++; $display("FAIL alu_wdata: got %h expected 12345678", rf_wdata); end
        n_cmp++; if (cancel !== 1'b0 || exc_valid !== 1'b0) begin n_mis++; $display("FAIL alu_cancel: got %h/%h expected 0/0", cancel, exc_valid); end
        n_cmp++; if (WB_valid !== 1'b1 || WB_over !== 1'b1) begin n_mis++; $display("FAIL alu_valid: got %h/%h expected 1/1", WB_valid, WB_over); end
        n_cmp++; if (debug_wb_pc !== 32'hBFC00000) begin n_mis++; $display("FAIL alu_pc: got %h expected bfc00000", debug_wb_pc); end
        b.wdest = 5'd7; b.wbytes = 4'b0011; b.pc = 32'hBFC00004;
        issue(b);
        n_cmp++; if (rf_wen !== 4'h3 || rf_wdest !== 5'd7) begin n_mis++; $display("FAIL alu_partial: got %h/%h expected 3/07", rf_wen, rf_wdest); end
        step();
        n_cmp++; if (WB_valid !== 1'b0 || WB_wdest !== 5'd0 || rf_wen !== 4'h0) begin n_mis++; $display("FAIL alu_idle: got %h/%h/%h expected 0/00/0", WB_valid, WB_wdest, rf_wen); end
    endtask

    task automatic test_delay_slot();
        b = '0; b.inst_jbr = 1'b1; b.pc = 32'hBFC00100;
        issue(b);
        b = '0; b.syscall = 1'b1; b.wen = 1'b1; b.wdest = 5'd3; b.wbytes = 4'hF;
        b.mem_result = 32'hDEADBEEF; b.pc = 32'hBFC00104;
        issue(b);
        n_cmp++; if (cancel !== 1'b1 || exc_valid !== 1'b1) begin n_mis++; $display("FAIL ds_cancel: got %h/%h expected 1/1", cancel, exc_valid); end
        n_cmp++; if (exc_pc !== 32'hBFC00380) begin n_mis++; $display("FAIL ds_exc_pc: got %h expected bfc00380", exc_pc); end
        n_cmp++; if (rf_wen !== 4'h0) begin n_mis++; $display("FAIL ds_wen: got %h expected 0", rf_wen); end
        // An instruction offered during the flush must not be latched.
        b = '0; b.wen = 1'b1; b.wdest = 5'd9; b.wbytes = 4'hF; b.pc = 32'hBFC00108;
        MEM_WB_bus = b; MEM_over = 1'b1;
        step();
        MEM_over = 1'b0;
        n_cmp++; if (WB_valid !== 1'b0 || cancel !== 1'b0) begin n_mis++; $display("FAIL ds_flush: got %h/%h expected 0/0", WB_valid, cancel); end
        n_cmp++; if (cp0r_epc !== 32'hBFC00100) begin n_mis++; $display("FAIL ds_epc: got %h expected bfc00100", cp0r_epc); end
        n_cmp++; if (cp0r_cause !== 32'h80000020) begin n_mis++; $display("FAIL ds_cause: got %h expected 80000020", cp0r_cause); end
        n_cmp++; if (cp0r_status !== 32'h00400002) begin n_mis++; $display("FAIL ds_status: got %h expected 00400002", cp0r_status); end
        eret_at(32'h80000010);
        n_cmp++; if (cancel !== 1'b1 || exc_pc !== 32'hBFC00100) begin n_mis++; $display("FAIL ds_eret: got %h/%h expected 1/bfc00100", cancel, exc_pc); end
        step();
        n_cmp++; if (cp0r_status !== 32'h00400000 || cancel !== 1'b0) begin n_mis++; $display("FAIL ds_eret_exl: got %h/%h expected 00400000/0", cp0r_status, cancel); end
    endtask

    task automatic test_adel();
        b = '0; b.adel = 1'b1; b.exe_result = 32'h80000003; b.wen = 1'b1; b.wdest = 5'd8;
        b.wbytes = 4'hF; b.pc = 32'h80000020;
        issue(b);
        n_cmp++; if (rf_wen !== 4'h0 || cancel !== 1'b1) begin n_mis++; $display("FAIL adel_now: got %h/%h expected 0/1", rf_wen, cancel); end
        step();
        n_cmp++; if (cp0r_badvaddr !== 32'h80000003) begin n_mis++; $display("FAIL adel_badv: got %h expected 80000003", cp0r_badvaddr); end
        n_cmp++; if (cp0r_cause !== 32'h00000010 || cp0r_epc !== 32'h80000020) begin n_mis++; $display("FAIL adel_cause_epc: got %h/%h expected 00000010/80000020", cp0r_cause, cp0r_epc); end
        eret_at(32'h80000024);
        n_cmp++; if (exc_pc !== 32'h80000020) begin n_mis++; $display("FAIL adel_eret_pc: got %h expected 80000020", exc_pc); end
        step();
    endtask

    task automatic test_mtc0();
        b = '0; b.mtc0 = 1'b1; b.cp0_addr = {5'd12, 3'd0}; b.mem_result = 32'hFFFFFFFF; b.pc = 32'h80000100;
        issue(b);
        n_cmp++; if (cancel !== 1'b0 || rf_wen !== 4'h0) begin n_mis++; $display("FAIL mtc0_now: got %h/%h expected 0/0", cancel, rf_wen); end
        step();
        n_cmp++; if (cp0r_status !== 32'h0040FF03) begin n_mis++; $display("FAIL mtc0_status: got %h expected 0040ff03", cp0r_status); end
        b.cp0_addr = {5'd13, 3'd0};
        issue(b); step();
        n_cmp++; if (cp0r_cause !== 32'h00000310) begin n_mis++; $display("FAIL mtc0_cause_set: got %h expected 00000310", cp0r_cause); end
        b.mem_result = 32'h0;
        issue(b); step();
        n_cmp++; if (cp0r_cause !== 32'h00000010) begin n_mis++; $display("FAIL mtc0_cause_clr: got %h expected 00000010", cp0r_cause); end
        b.cp0_addr = {5'd8, 3'd0}; b.mem_result = 32'h12345678;
        issue(b); step();
        n_cmp++; if (cp0r_badvaddr !== 32'h80000003) begin n_mis++; $display("FAIL mtc0_badv_ro: got %h expected 80000003", cp0r_badvaddr); end
        b.cp0_addr = {5'd14, 3'd0}; b.mem_result = 32'h80001000;
        issue(b); step();
        n_cmp++; if (cp0r_epc !== 32'h80001000) begin n_mis++; $display("FAIL mtc0_epc: got %h expected 80001000", cp0r_epc); end
        eret_at(32'h80000200);
        n_cmp++; if (exc_pc !== 32'h80001000 || exc_valid !== 1'b1) begin n_mis++; $display("FAIL mtc0_eret_pc: got %h/%h expected 80001000/1", exc_pc, exc_valid); end
        step();
        n_cmp++; if (cp0r_status !== 32'h0040FF01) begin n_mis++; $display("FAIL mtc0_eret_exl: got %h expected 0040ff01", cp0r_status); end
    endtask

    task automatic test_interrupt();
        hw_int = 6'b000001;
        step();
        n_cmp++; if (cp0r_cause !== 32'h00000410) begin n_mis++; $display("FAIL int_ip: got %h expected 00000410", cp0r_cause); end
        n_cmp++; if (cancel !== 1'b0) begin n_mis++; $display("FAIL int_idle_cancel: got %h expected 0", cancel); end
        b = '0; b.wen = 1'b1; b.wdest = 5'd4; b.wbytes = 4'hF; b.pc = 32'h80002000;
        issue(b);
        n_cmp++; if (cancel !== 1'b1 || rf_wen !== 4'h0 || exc_pc !== 32'hBFC00380) begin n_mis++; $display("FAIL int_take: got %h/%h/%h expected 1/0/bfc00380", cancel, rf_wen, exc_pc); end
        step();
        n_cmp++; if (cp0r_cause !== 32'h00000400 || cp0r_epc !== 32'h80002000) begin n_mis++; $display("FAIL int_commit: got %h/%h expected 00000400/80002000", cp0r_cause, cp0r_epc); end
        hw_int = 6'd0;
        step();
        n_cmp++; if (cp0r_cause !== 32'h0 || cp0r_status !== 32'h0040FF03) begin n_mis++; $display("FAIL int_clear: got %h/%h expected 00000000/0040ff03", cp0r_cause, cp0r_status); end
        eret_at(32'h80002100);
        step();
    endtask

    task automatic test_priority();
        b = '0; b.ri = 1'b1; b.ov = 1'b1; b.syscall = 1'b1; b.brk = 1'b1; b.adel = 1'b1;
        b.mtc0 = 1'b1; b.cp0_addr = {5'd14, 3'd0}; b.mem_result = 32'h11111111;
        b.exe_result = 32'h22222222; b.pc = 32'h80003000;
        issue(b);
        n_cmp++; if (cancel !== 1'b1) begin n_mis++; $display("FAIL prio_cancel: got %h expected 1", cancel); end
        step();
        n_cmp++; if (cp0r_cause !== 32'h00000028) begin n_mis++; $display("FAIL prio_code_ri: got %h expected 00000028", cp0r_cause); end
        n_cmp++; if (cp0r_epc !== 32'h80003000 || cp0r_badvaddr !== 32'h80000003) begin n_mis++; $display("FAIL prio_epc_badv: got %h/%h expected 80003000/80000003", cp0r_epc, cp0r_badvaddr); end
        eret_at(32'h80003100); step();
        b = '0; b.ades = 1'b1; b.exe_result = 32'hA0000006; b.pc = 32'h80004000;
        issue(b); step();
        n_cmp++; if (cp0r_cause !== 32'h00000014 || cp0r_badvaddr !== 32'hA0000006) begin n_mis++; $display("FAIL ades: got %h/%h expected 00000014/a0000006", cp0r_cause, cp0r_badvaddr); end
        eret_at(32'h80004100); step();
        n_cmp++; if (cp0r_status !== 32'h0040FF01) begin n_mis++; $display("FAIL prio_status: got %h expected 0040ff01", cp0r_status); end
    endtask

    task automatic test_back_to_back_hilo();
        b = '0; b.hi_write = 1'b1; b.lo_write = 1'b1; b.mem_result = 32'd1; b.lo_result = 32'd2; b.pc = 32'h80006000;
        issue(b);
        n_cmp++; if (WB_hi_write !== 1'b1 || WB_lo_write !== 1'b1) begin n_mis++; $display("FAIL hilo_fwd_we: got %h/%h expected 1/1", WB_hi_write, WB_lo_write); end
        n_cmp++; if (WB_lo_data !== 32'd2 || WB_hi_data !== 32'd1) begin n_mis++; $display("FAIL hilo_fwd_data: got %h/%h expected 2/1", WB_lo_data, WB_hi_data); end
        n_cmp++; if (LO_data !== 32'd0 || HI_data !== 32'd0) begin n_mis++; $display("FAIL hilo_arch_early: got %h/%h expected 0/0", LO_data, HI_data); end
        b = '0; b.mflo = 1'b1; b.wen = 1'b1; b.wdest = 5'd10; b.wbytes = 4'hF; b.mem_result = 32'h55555555; b.pc = 32'h80006004;
        issue(b);
        n_cmp++; if (rf_wdata !== 32'd2 || rf_wen !== 4'hF) begin n_mis++; $display("FAIL mflo: got %h/%h expected 00000002/f", rf_wdata, rf_wen); end
        n_cmp++; if (LO_data !== 32'd2 || HI_data !== 32'd1) begin n_mis++; $display("FAIL hilo_arch: got %h/%h expected 2/1", LO_data, HI_data); end
        b.mflo = 1'b0; b.mfhi = 1'b1;
        issue(b);
        n_cmp++; if (rf_wdata !== 32'd1) begin n_mis++; $display("FAIL mfhi: got %h expected 00000001", rf_wdata); end
        b.mfhi = 1'b0; b.mfc0 = 1'b1; b.cp0_addr = {5'd12, 3'd0};
        issue(b);
        n_cmp++; if (rf_wdata !== 32'h0040FF01) begin n_mis++; $display("FAIL mfc0_status: got %h expected 0040ff01", rf_wdata); end
        b.cp0_addr = {5'd14, 3'd0};
        issue(b);
        n_cmp++; if (rf_wdata !== 32'h80004000) begin n_mis++; $display("FAIL mfc0_epc: got %h expected 80004000", rf_wdata); end
        b = '0; b.hi_write = 1'b1; b.mem_result = 32'h77; b.ov = 1'b1; b.pc = 32'h80005000;
        issue(b);
        n_cmp++; if (WB_hi_write !== 1'b0 || cancel !== 1'b1) begin n_mis++; $display("FAIL ov_hi_suppress: got %h/%h expected 0/1", WB_hi_write, cancel); end
        step();
        n_cmp++; if (HI_data !== 32'd1 || cp0r_cause !== 32'h00000030) begin n_mis++; $display("FAIL ov_commit: got %h/%h expected 00000001/00000030", HI_data, cp0r_cause); end
    endtask

    task automatic test_reset_mid_flush();
        eret_at(32'h80005100);
        n_cmp++; if (cancel !== 1'b1 || exc_pc !== 32'h80005000) begin n_mis++; $display("FAIL rmf_pre: got %h/%h expected 1/80005000", cancel, exc_pc); end
        resetn = 1'b1;
        step();
        n_cmp++; if (WB_valid !== 1'b0 || cancel !== 1'b0) begin n_mis++; $display("FAIL rmf_valid_cancel: got %h/%h expected 0/0", WB_valid, cancel); end
        n_cmp++; if (cp0r_status !== 32'h00400000) begin n_mis++; $display("FAIL rmf_status: got %h expected 00400000", cp0r_status); end
        n_cmp++; if (cp0r_epc !== 32'h0 || HI_data !== 32'h0) begin n_mis++; $display("FAIL rmf_epc_hi: got %h/%h expected 0/0", cp0r_epc, HI_data); end
        resetn = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_delay_slot();
        test_adel();
        test_mtc0();
        test_interrupt();
        test_priority();
        test_back_to_back_hilo();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
